read_burst_issuer: RTL and testbench
====================================

Name: read_burst_issuer

Overview:
Sits directly downstream of the multipass address calculator. For each run it takes the per-leaf read addresses and the per-node byte count, and issues AXI4 read bursts round-robin across leaf channels on one shared AR channel. It steers returning R beats to the owning leaf stream by ARID and pulses single_run_read_done once every burst of the run has fully returned.

Parameters:
NUM_READ_CHANNELS, 4, number of leaf read channels (power of 2, ≥2)
C_M_AXI_ADDR_WIDTH, 64, AXI address width
C_M_AXI_DATA_WIDTH, 512, AXI data width; beat = 64 B
C_XFER_SIZE_WIDTH, 64, byte-count width
C_BURST_SIZE_BYTES, 1024, full burst size (16 beats)
C_MAX_OUTSTANDING, 16, maximum AR bursts in flight without last beat returned

Ports:
aclk  in  1  clock
areset  in  1  asynchronous, active-high reset
read_start  in  1  one-cycle pulse: latch run parameters and begin
read_addr  in  NUM_READ_CHANNELS*C_M_AXI_ADDR_WIDTH  per-channel start address (packed, ch0 in LSBs)
read_size_in_bytes  in  C_XFER_SIZE_WIDTH  bytes per channel this run, multiple of 64
busy  out  1  run in progress
single_run_read_done  out  1  one-cycle pulse at end of run
start_err  out  1  sticky; read_start arrived while busy
m_axi_arvalid  out  1  AR valid
m_axi_arready  in  1  AR ready
m_axi_araddr  out  C_M_AXI_ADDR_WIDTH  burst address
m_axi_arlen  out  8  beats-1
m_axi_arid  out  log2(NUM_READ_CHANNELS)  owning channel
m_axi_rvalid  in  1  R valid
m_axi_rready  out  1  R ready
m_axi_rdata  in  C_M_AXI_DATA_WIDTH  R data
m_axi_rid  in  log2(NUM_READ_CHANNELS)  R id
m_axi_rlast  in  1  last beat of burst
ch_tvalid  out  NUM_READ_CHANNELS  per-leaf beat valid
ch_tready  in  NUM_READ_CHANNELS  per-leaf ready
ch_tdata  out  C_M_AXI_DATA_WIDTH  shared beat data (owner = asserted ch_tvalid bit)

Behaviour:
- Reset (async, immediate): FSM=IDLE; busy, arvalid, single_run_read_done, start_err, ch_tvalid = 0; counters and pointers = 0; araddr, arlen, arid = 0.
- Fixed fields: arsize = 6 and arburst = INCR, driven at the AXI top level.
- Per-channel burst plan:
  - full = size >> log2(BURST); rem = size[log2(BURST)-1:0].
  - Bursts per channel = full + (rem≠0). Full bursts use arlen = 15. The final partial burst uses arlen = rem/64 − 1.
  - Size 0: no bursts; run completes immediately.
- FSM: IDLE → ISSUE → DRAIN → DONE → IDLE.
  - IDLE: on read_start, latch addresses and size into per-channel cursors; set chan_ptr = 0; busy = 1 next cycle; enter ISSUE.
  - ISSUE: present the burst for chan_ptr.
    - arvalid holds stable until handshake.
    - On handshake: cursor[chan_ptr] += (arlen+1)*64; decrement that channel's remaining count; advance chan_ptr to the next channel with bursts left (wrap at N−1).
    - Order per round is ch0, ch1, …, chN−1.
    - arvalid is deasserted while outstanding == C_MAX_OUTSTANDING.
    - When all channels are exhausted, enter DRAIN.
  - DRAIN: wait for outstanding == 0, then enter DONE.
  - DONE: single_run_read_done = 1 for exactly one cycle; busy = 0 from the following cycle; return to IDLE.
- Outstanding counter: +1 on AR handshake, −1 on R handshake with rlast. Both in the same cycle → unchanged.
- R steering (combinational):
  - ch_tvalid[rid] = rvalid.
  - rready = ch_tready[rid].
  - ch_tdata = rdata.
  - No buffering; leaf backpressure stalls the R channel.
- R beats arriving in IDLE pass through unchanged and do not decrement below 0 (counter saturates at 0).
- read_start while busy: ignored; start_err set sticky until reset.
- read_start and DONE in the same cycle: start is ignored (busy still 1) and start_err is set.

Test Plan:
- N=4, size=1024, addr={0x1000,0x1400,0x1800,0x1C00}, arready=1, R returns 16 beats/burst → 4 ARs (arid 0..3, arlen 15, those addresses); done pulses once 1 cycle after final rlast is counted; busy drops the next cycle.
- size=2048, same bases → 8 ARs in order ch0..3, ch0..3; second round addresses 0x1400, 0x1800, 0x1C00, 0x2000; 128 beats total before done.
- size=1088 → per channel, arlen 15 then arlen 0; 2nd ch0 address base+0x400; done after 68 beats.
- arready=1 with no R returns, size=8192 → exactly 16 ARs accepted, then arvalid=0; returning one rlast allows exactly one more AR.
- R id=2 with ch_tready[2]=0 → rready=0 and ch_tvalid=4'b0100 until ready rises; a second read_start mid-run sets start_err=1 and no new ARs are issued.
- areset asserted mid-ISSUE with arvalid=1 → arvalid=0 and busy=0 in the same cycle; a new run after release behaves as in scenario 1.

Source files
------------

// File: rtl/read_burst_issuer.sv
// rtl/read_burst_issuer.sv - round-robin AXI4 read burst issuer with per-leaf R steering
//
// Purpose: takes a per-leaf start address and a shared byte count for one run,
// splits each leaf's range into 1 KiB bursts (plus one short tail burst), and
// issues them on a single AR channel in round-robin order. ARID is the owning
// leaf. Returning R beats are routed combinationally to the owning leaf stream.
// A one-cycle done pulse marks the point at which every burst of the run has
// returned its last beat.
//
// Ports:
//   aclk, areset           clock, asynchronous active-high reset
//   read_start             one-cycle pulse: latch read_addr/read_size_in_bytes, begin run
//   read_addr              per-leaf start addresses, leaf 0 in the LSBs
//   read_size_in_bytes     bytes per leaf for this run, multiple of 64
//   busy                   run in progress
//   single_run_read_done   one-cycle pulse at the end of a run
//   start_err              sticky: read_start seen while a run was in progress
//   m_axi_ar*              AR channel master (arsize/arburst fixed at the AXI top)
//   m_axi_r*               R channel master
//   ch_tvalid/tready/tdata per-leaf beat streams; tdata is shared, owner = tvalid bit

module read_burst_issuer #(
  parameter int NUM_READ_CHANNELS  = 4,
  parameter int C_M_AXI_ADDR_WIDTH = 64,
  parameter int C_M_AXI_DATA_WIDTH = 512,
  parameter int C_XFER_SIZE_WIDTH  = 64,
  parameter int C_BURST_SIZE_BYTES = 1024,
  parameter int C_MAX_OUTSTANDING  = 16,
  localparam int ID_W = $clog2(NUM_READ_CHANNELS)
) (
  input  logic                                            aclk,
  input  logic                                            areset,
  input  logic                                            read_start,
  input  logic [NUM_READ_CHANNELS*C_M_AXI_ADDR_WIDTH-1:0] read_addr,
  input  logic [C_XFER_SIZE_WIDTH-1:0]                    read_size_in_bytes,
  output logic                                            busy,
  output logic                                            single_run_read_done,
  output logic                                            start_err,
  output logic                                            m_axi_arvalid,
  input  logic                                            m_axi_arready,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]                   m_axi_araddr,
  output logic [7:0]                                      m_axi_arlen,
  output logic [ID_W-1:0]                                 m_axi_arid,
  input  logic                                            m_axi_rvalid,
  output logic                                            m_axi_rready,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]                   m_axi_rdata,
  input  logic [ID_W-1:0]                                 m_axi_rid,
  input  logic                                            m_axi_rlast,
  output logic [NUM_READ_CHANNELS-1:0]                    ch_tvalid,
  input  logic [NUM_READ_CHANNELS-1:0]                    ch_tready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]                   ch_tdata
);

  localparam int N           = NUM_READ_CHANNELS;
  localparam int AW          = C_M_AXI_ADDR_WIDTH;
  localparam int XW          = C_XFER_SIZE_WIDTH;
  localparam int BEAT_SHIFT  = 6;
  localparam int BURST_SHIFT = $clog2(C_BURST_SIZE_BYTES);
  localparam int OUT_W       = $clog2(C_MAX_OUTSTANDING + 1);
  localparam logic [7:0] FULL_LEN = 8'((C_BURST_SIZE_BYTES >> BEAT_SHIFT) - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [AW-1:0]         cursor_q [N];
  logic [AW-1:0]         cursor_d [N];
  logic [XW-1:0]         left_q [N];
  logic [XW-1:0]         left_d [N];
  logic [ID_W-1:0]       chan_ptr_q, chan_ptr_d;
  logic                  has_partial_q, has_partial_d;
  logic [7:0]            last_len_q, last_len_d;
  logic [OUT_W-1:0]      out_q, out_d;
  logic                  start_err_q, start_err_d;

  logic                  ar_fire;
  logic                  r_last_fire;
  logic                  left_empty_d;
  logic [BURST_SHIFT-1:0] size_rem;
  logic [XW-1:0]         size_bursts;
  logic [AW-1:0]         burst_bytes;
  logic [ID_W-1:0]       scan_idx;
  logic                  scan_found;

  assign size_rem    = read_size_in_bytes[BURST_SHIFT-1:0];
  assign size_bursts = (read_size_in_bytes >> BURST_SHIFT) + XW'(|size_rem);
  assign ar_fire     = m_axi_arvalid & m_axi_arready;
  assign r_last_fire = m_axi_rvalid & m_axi_rready & m_axi_rlast;
  assign burst_bytes = (AW'(m_axi_arlen) + AW'(1)) << BEAT_SHIFT;

  // ---------------------------------------------------------------- registers
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q       <= S_IDLE;
      chan_ptr_q    <= '0;
      has_partial_q <= 1'b0;
      last_len_q    <= '0;
      out_q         <= '0;
      start_err_q   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        cursor_q[i] <= '0;
        left_q[i]   <= '0;
      end
    end else begin
      state_q       <= state_d;
      chan_ptr_q    <= chan_ptr_d;
      has_partial_q <= has_partial_d;
      last_len_q    <= last_len_d;
      out_q         <= out_d;
      start_err_q   <= start_err_d;
      for (int i = 0; i < N; i++) begin
        cursor_q[i] <= cursor_d[i];
        left_q[i]   <= left_d[i];
      end
    end
  end

  // ------------------------------------------------ burst plan and cursors
  always_comb begin
    cursor_d      = cursor_q;
    left_d        = left_q;
    chan_ptr_d    = chan_ptr_q;
    has_partial_d = has_partial_q;
    last_len_d    = last_len_q;
    scan_idx      = chan_ptr_q;
    scan_found    = 1'b0;
    if (state_q == S_IDLE && read_start) begin
      for (int i = 0; i < N; i++) begin
        cursor_d[i] = read_addr[i*AW +: AW];
        left_d[i]   = size_bursts;
      end
      chan_ptr_d    = '0;
      has_partial_d = |size_rem;
      last_len_d    = 8'(size_rem[BURST_SHIFT-1:BEAT_SHIFT]) - 8'd1;
    end else if (ar_fire) begin
      cursor_d[chan_ptr_q] = cursor_q[chan_ptr_q] + burst_bytes;
      left_d[chan_ptr_q]   = left_q[chan_ptr_q] - XW'(1);
      // Scan ptr+1 .. ptr (wrapping); the current channel is visited last so
      // the round order stays ch0..chN-1.
      for (int k = 1; k <= N; k++) begin
        scan_idx = chan_ptr_q + ID_W'(k);
        if (!scan_found && left_d[scan_idx] != '0) begin
          chan_ptr_d = scan_idx;
          scan_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    left_empty_d = 1'b1;
    for (int i = 0; i < N; i++) begin
      if (left_d[i] != '0) left_empty_d = 1'b0;
    end
  end

  // A stray rlast with nothing in flight (e.g. after a reset) is not counted.
  always_comb begin
    out_d = out_q;
    if (ar_fire && !(r_last_fire && out_q != '0)) begin
      out_d = out_q + OUT_W'(1);
    end else if (!ar_fire && r_last_fire && out_q != '0) begin
      out_d = out_q - OUT_W'(1);
    end
  end

  assign start_err_d = start_err_q | (read_start & (state_q != S_IDLE));

  // ---------------------------------------------------------- FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (read_start) state_d = S_ISSUE;
      S_ISSUE: if (left_empty_d) state_d = S_DRAIN;
      // Looking at out_d lets done follow the final rlast by one cycle.
      S_DRAIN: if (out_d == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------- FSM outputs
  always_comb begin
    busy                 = (state_q != S_IDLE);
    single_run_read_done = (state_q == S_DONE);
    start_err            = start_err_q;
    m_axi_arvalid        = 1'b0;
    m_axi_araddr         = '0;
    m_axi_arlen          = '0;
    m_axi_arid           = '0;
    if (state_q == S_ISSUE) begin
      m_axi_arvalid = (left_q[chan_ptr_q] != '0) && (out_q < OUT_W'(C_MAX_OUTSTANDING));
      m_axi_araddr  = cursor_q[chan_ptr_q];
      m_axi_arid    = chan_ptr_q;
      m_axi_arlen   = (has_partial_q && left_q[chan_ptr_q] == XW'(1)) ? last_len_q : FULL_LEN;
    end
  end

  // ------------------------------------------------------------- R steering
  always_comb begin
    ch_tvalid            = '0;
    ch_tvalid[m_axi_rid] = m_axi_rvalid;
  end

  assign m_axi_rready = ch_tready[m_axi_rid];
  assign ch_tdata     = m_axi_rdata;

endmodule

// File: tb/tb_read_burst_issuer.sv
// tb/tb_read_burst_issuer.sv - self-checking bench for read_burst_issuer
module tb_read_burst_issuer;

  localparam int N  = 4;
  localparam int AW = 64;
  localparam int DW = 512;
  localparam int XW = 64;

  logic            aclk = 1'b0;
  logic            areset;
  logic            read_start;
  logic [N*AW-1:0] read_addr;
  logic [XW-1:0]   read_size_in_bytes;
  logic            busy, single_run_read_done, start_err;
  logic            m_axi_arvalid, m_axi_arready;
  logic [AW-1:0]   m_axi_araddr;
  logic [7:0]      m_axi_arlen;
  logic [1:0]      m_axi_arid;
  logic            m_axi_rvalid, m_axi_rready, m_axi_rlast;
  logic [DW-1:0]   m_axi_rdata;
  logic [1:0]      m_axi_rid;
  logic [N-1:0]    ch_tvalid, ch_tready;
  logic [DW-1:0]   ch_tdata;

  always #5 aclk = ~aclk;

  read_burst_issuer dut (
    .aclk(aclk), .areset(areset), .read_start(read_start), .read_addr(read_addr),
    .read_size_in_bytes(read_size_in_bytes), .busy(busy),
    .single_run_read_done(single_run_read_done), .start_err(start_err),
    .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arid(m_axi_arid),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready), .m_axi_rdata(m_axi_rdata),
    .m_axi_rid(m_axi_rid), .m_axi_rlast(m_axi_rlast),
    .ch_tvalid(ch_tvalid), .ch_tready(ch_tready), .ch_tdata(ch_tdata)
  );

  typedef struct { logic [63:0] addr; int len; int id; } ar_t;
  typedef struct { int id; int len; } burst_t;

  ar_t         exp_ar[$];
  ar_t         ar_log[$];
  burst_t      pend[$];
  logic [63:0] bases [N];
  int          beats_ch [N];
  int          exp_beats_ch [N];
  int          beat_idx, r_budget;
  bit          r_gaps, tr_rand, ar_rand, ar_block, start_req, r_hold;
  logic [N-1:0] tready_hold;
  int          cyc, done_cnt, done_cyc, last_rlast_cyc, busy_after_done, steer_bad;
  logic        s_arvalid, s_rvalid, s_rready, s_busy;
  logic [N-1:0] s_tvalid;
  logic [1:0]  s_rid;
  logic [DW-1:0] cur_data;
  int          n_cmp, n_fail;

  task automatic new_data();
    for (int w = 0; w < DW/32; w++) cur_data[w*32 +: 32] = $urandom;
  endtask

  // One bus cycle: drive inputs after negedge, sample 1 ns later, and book the
  // handshakes that the following posedge will complete.
  task automatic tick();
    @(negedge aclk);
    read_start = start_req;
    start_req  = 1'b0;
    m_axi_arready = ar_block ? 1'b0 : (ar_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    ch_tready = (tr_rand ? N'($urandom) : {N{1'b1}}) & ~tready_hold;
    if (pend.size() > 0 && r_budget != 0 && (r_hold || !r_gaps || $urandom_range(0, 2) != 0)) begin
      m_axi_rvalid = 1'b1;
      m_axi_rid    = 2'(pend[0].id);
      m_axi_rlast  = (beat_idx == pend[0].len);
      m_axi_rdata  = cur_data;
    end else begin
      m_axi_rvalid = 1'b0;
      m_axi_rlast  = 1'b0;
    end
    #1;
    s_arvalid = m_axi_arvalid; s_rvalid = m_axi_rvalid; s_rready = m_axi_rready;
    s_busy = busy; s_tvalid = ch_tvalid; s_rid = m_axi_rid;
    if (m_axi_rvalid) begin
      if (ch_tvalid !== (N'(1) << m_axi_rid) || ch_tdata !== m_axi_rdata ||
          m_axi_rready !== ch_tready[m_axi_rid]) steer_bad++;
    end else if (ch_tvalid !== '0) steer_bad++;
    r_hold = m_axi_rvalid && !m_axi_rready;
    if (m_axi_rvalid && m_axi_rready) begin
      beats_ch[m_axi_rid]++;
      new_data();
      if (m_axi_rlast) begin
        void'(pend.pop_front());
        beat_idx = 0;
        last_rlast_cyc = cyc;
        if (r_budget > 0) r_budget--;
      end else beat_idx++;
    end
    if (m_axi_arvalid && m_axi_arready) begin
      ar_log.push_back('{m_axi_araddr, int'(m_axi_arlen), int'(m_axi_arid)});
      pend.push_back('{int'(m_axi_arid), int'(m_axi_arlen)});
    end
    if (single_run_read_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (cyc == done_cyc + 1) busy_after_done = int'(busy);
    cyc++;
  endtask

  task automatic clear_run();
    ar_log.delete(); exp_ar.delete();
    done_cnt = 0; done_cyc = -10; last_rlast_cyc = -10; busy_after_done = -1; steer_bad = 0;
    for (int c = 0; c < N; c++) begin beats_ch[c] = 0; exp_beats_ch[c] = 0; end
  endtask

  // Reference plan: ceil(size/1KiB) rounds, each round visits ch0..chN-1;
  // the last round is short when size is not a multiple of 1 KiB.
  task automatic build_exp(input longint unsigned size);
    longint unsigned rounds, rem;
    int len;
    rounds = (size + 1023) / 1024;
    rem    = size % 1024;
    for (longint unsigned r = 0; r < rounds; r++) begin
      for (int c = 0; c < N; c++) begin
        len = (r == rounds - 1 && rem != 0) ? int'(rem / 64) - 1 : 15;
        exp_ar.push_back('{bases[c] + r * 1024, len, c});
        exp_beats_ch[c] += len + 1;
      end
    end
  endtask

  task automatic start_run(input logic [63:0] size);
    for (int c = 0; c < N; c++) read_addr[c*AW +: AW] = bases[c];
    read_size_in_bytes = size;
    start_req = 1'b1;
    tick();
  endtask

  task automatic run_to_done(input int limit, output bit timed_out);
    int t = 0;
    while (done_cnt == 0 && t < limit) begin tick(); t++; end
    timed_out = (done_cnt == 0);
    tick(); tick();
  endtask

  task automatic set_plan_bases();
    for (int c = 0; c < N; c++) bases[c] = 64'h1000 + 64'(c) * 64'h400;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) @(posedge aclk);
    @(negedge aclk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_cmp++; if (single_run_read_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", single_run_read_done); end
    n_cmp++; if (start_err !== 1'b0) begin n_fail++; $display("FAIL reset_start_err got %b want 0", start_err); end
    n_cmp++; if (m_axi_arvalid !== 1'b0) begin n_fail++; $display("FAIL reset_arvalid got %b want 0", m_axi_arvalid); end
    n_cmp++; if (ch_tvalid !== '0) begin n_fail++; $display("FAIL reset_tvalid got %b want 0", ch_tvalid); end
    n_cmp++; if (m_axi_araddr !== '0 || m_axi_arlen !== '0 || m_axi_arid !== '0) begin
      n_fail++; $display("FAIL reset_ar_fields got %h/%0d/%0d want 0/0/0", m_axi_araddr, m_axi_arlen, m_axi_arid);
    end
    areset = 1'b0;
  endtask

  task automatic test_burst_plan(input logic [63:0] size, input bit rand_flow);
    bit to;
    clear_run();
    build_exp(size);
    r_gaps = rand_flow; tr_rand = rand_flow; ar_rand = rand_flow; r_budget = -1;
    start_run(size);
    run_to_done(3000, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL plan_timeout size=%0d got done=%0d want 1", size, done_cnt); end
    n_cmp++; if (ar_log.size() != exp_ar.size()) begin
      n_fail++; $display("FAIL plan_ar_count size=%0d got %0d want %0d", size, ar_log.size(), exp_ar.size());
    end
    for (int i = 0; i < exp_ar.size() && i < ar_log.size(); i++) begin
      n_cmp++;
      if (ar_log[i].addr !== exp_ar[i].addr || ar_log[i].len != exp_ar[i].len || ar_log[i].id != exp_ar[i].id) begin
        n_fail++;
        $display("FAIL plan_ar[%0d] size=%0d got %h/%0d/%0d want %h/%0d/%0d", i, size, ar_log[i].addr,
                 ar_log[i].len, ar_log[i].id, exp_ar[i].addr, exp_ar[i].len, exp_ar[i].id);
      end
    end
    for (int c = 0; c < N; c++) begin
      n_cmp++; if (beats_ch[c] != exp_beats_ch[c]) begin
        n_fail++; $display("FAIL plan_beats ch%0d size=%0d got %0d want %0d", c, size, beats_ch[c], exp_beats_ch[c]);
      end
    end
    n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL plan_done_pulses size=%0d got %0d want 1", size, done_cnt); end
    if (size != 0) begin
      n_cmp++; if (done_cyc != last_rlast_cyc + 1) begin
        n_fail++; $display("FAIL plan_done_timing size=%0d got cycle %0d want %0d", size, done_cyc, last_rlast_cyc + 1);
      end
    end
    n_cmp++; if (busy_after_done != 0) begin n_fail++; $display("FAIL plan_busy_drop size=%0d got %0d want 0", size, busy_after_done); end
    n_cmp++; if (steer_bad != 0) begin n_fail++; $display("FAIL plan_steering size=%0d got %0d bad beats want 0", size, steer_bad); end
  endtask

  task automatic test_outstanding();
    bit to;
    set_plan_bases();
    clear_run();
    build_exp(8192);
    r_gaps = 0; tr_rand = 0; ar_rand = 0; r_budget = 0;
    start_run(8192);
    repeat (40) tick();
    n_cmp++; if (ar_log.size() != 16) begin n_fail++; $display("FAIL outst_cap got %0d ARs want 16", ar_log.size()); end
    n_cmp++; if (s_arvalid !== 1'b0) begin n_fail++; $display("FAIL outst_arvalid got %b want 0", s_arvalid); end
    r_budget = 1;
    repeat (40) tick();
    n_cmp++; if (ar_log.size() != 17) begin n_fail++; $display("FAIL outst_one_more got %0d ARs want 17", ar_log.size()); end
    n_cmp++; if (s_arvalid !== 1'b0) begin n_fail++; $display("FAIL outst_arvalid2 got %b want 0", s_arvalid); end
    r_budget = -1;
    run_to_done(3000, to);
    n_cmp++; if (to) begin n_fail++; $display("FAIL outst_timeout got done=%0d want 1", done_cnt); end
    n_cmp++; if (ar_log.size() != exp_ar.size()) begin
      n_fail++; $display("FAIL outst_ar_total got %0d want %0d", ar_log.size(), exp_ar.size());
    end
    for (int i = 0; i < exp_ar.size() && i < ar_log.size(); i++) begin
      n_cmp++;
      if (ar_log[i].addr !== exp_ar[i].addr || ar_log[i].len != exp_ar[i].len || ar_log[i].id != exp_ar[i].id) begin
        n_fail++;
        $display("FAIL outst_ar[%0d] got %h/%0d/%0d want %h/%0d/%0d", i, ar_log[i].addr, ar_log[i].len,
                 ar_log[i].id, exp_ar[i].addr, exp_ar[i].len, exp_ar[i].id);
      end
    end
  endtask

  task automatic test_backpressure();
    bit to;
    int t;
    set_plan_bases();
    clear_run();
    r_gaps = 0; tr_rand = 0; ar_rand = 0; r_budget = -1;
    tready_hold = 4'b0100;
    start_run(1024);
    t = 0;
    while (!(s_rvalid && s_rid == 2'd2) && t < 300) begin tick(); t++; end
    n_cmp++; if (t >= 300) begin n_fail++; $display("FAIL bp_no_rid2 got timeout want rid 2 beat"); end
    n_cmp++; if (s_rready !== 1'b0) begin n_fail++; $display("FAIL bp_rready got %b want 0", s_rready); end
    n_cmp++; if (s_tvalid !== 4'b0100) begin n_fail++; $display("FAIL bp_tvalid got %b want 0100", s_tvalid); end
    start_req = 1'b1;
    tick();
    repeat (3) tick();
    n_cmp++; if (start_err !== 1'b1) begin n_fail++; $display("FAIL bp_start_err got %b want 1", start_err); end
    n_cmp++; if (beats_ch[2] != 0) begin n_fail++; $display("FAIL bp_stalled got %0d beats want 0", beats_ch[2]); end
    n_cmp++; if (s_tvalid !== 4'b0100 || s_rready !== 1'b0) begin
      n_fail++; $display("FAIL bp_hold got tvalid=%b rready=%b want 0100/0", s_tvalid, s_rready);
    end
    tready_hold = '0;
    run_to_done(500, to);
    repeat (10) tick();
    n_cmp++; if (to) begin n_fail++; $display("FAIL bp_timeout got done=%0d want 1", done_cnt); end
    n_cmp++; if (ar_log.size() != 4) begin n_fail++; $display("FAIL bp_ar_count got %0d want 4", ar_log.size()); end
    n_cmp++; if (done_cnt != 1) begin n_fail++; $display("FAIL bp_done_pulses got %0d want 1", done_cnt); end
    n_cmp++; if (s_busy !== 1'b0) begin n_fail++; $display("FAIL bp_idle_after got busy=%b want 0", s_busy); end
    n_cmp++; if (steer_bad != 0) begin n_fail++; $display("FAIL bp_steering got %0d bad want 0", steer_bad); end
  endtask

  task automatic test_reset_mid_issue();
    set_plan_bases();
    clear_run();
    r_gaps = 0; tr_rand = 0; ar_rand = 0; r_budget = -1;
    ar_block = 1'b1;
    start_run(2048);
    repeat (3) tick();
    n_cmp++; if (s_arvalid !== 1'b1 || s_busy !== 1'b1) begin
      n_fail++; $display("FAIL rst_pre got arvalid=%b busy=%b want 1/1", s_arvalid, s_busy);
    end
    #2 areset = 1'b1;
    #1;
    n_cmp++; if (m_axi_arvalid !== 1'b0) begin n_fail++; $display("FAIL rst_arvalid got %b want 0", m_axi_arvalid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    n_cmp++; if (start_err !== 1'b0) begin n_fail++; $display("FAIL rst_start_err got %b want 0", start_err); end
    @(negedge aclk);
    @(negedge aclk);
    pend.delete(); beat_idx = 0; r_hold = 1'b0; ar_block = 1'b0;
    areset = 1'b0;
    test_burst_plan(1024, 1'b0);
  endtask

  task automatic test_random();
    for (int it = 0; it < 5; it++) begin
      for (int c = 0; c < N; c++) bases[c] = 64'($urandom) << 6;
      test_burst_plan((it == 0) ? 64'd0 : 64'(64 * $urandom_range(1, 64)), 1'b1);
    end
  endtask

  initial begin
    n_cmp = 0; n_fail = 0; cyc = 0; beat_idx = 0; r_hold = 0; start_req = 0;
    r_gaps = 0; tr_rand = 0; ar_rand = 0; ar_block = 0; r_budget = -1; tready_hold = '0;
    read_start = 0; read_addr = '0; read_size_in_bytes = '0;
    m_axi_arready = 0; m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rid = '0; m_axi_rdata = '0;
    ch_tready = '1;
    new_data();
    clear_run();
    test_reset();
    set_plan_bases();
    test_burst_plan(1024, 1'b0);
    test_burst_plan(2048, 1'b0);
    test_burst_plan(1088, 1'b0);
    test_burst_plan(2048, 1'b1);
    test_outstanding();
    test_backpressure();
    test_reset_mid_issue();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got no completion want finish before 500us");
    $fatal(1, "watchdog");
  end

endmodule
